// File: rtl/fib_ctrl.sv
// fib_ctrl: Moore sequencer for an external 8-bit Fibonacci datapath
// (registers A, B, T, OUT and adder A+B). Issues one register operation
// per cycle, emits n terms through OUT, and stops early with a sticky
// overflow flag when the next sum would not fit in 8 bits.
module fib_ctrl #(
  parameter int N_W = 8
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           start,
  input  logic [N_W-1:0] n,
  input  logic           carry,
  output logic           clr_regs,
  output logic           ld_a,
  output logic           ld_b,
  output logic           sel_one,
  output logic           ld_t,
  output logic           ld_out,
  output logic           term_valid,
  output logic [N_W-1:0] term_idx,
  output logic           busy,
  output logic           done,
  output logic           ovf
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CLEAR     = 4'd1,
    S_INIT      = 4'd2,
    S_EMIT      = 4'd3,
    S_SUM       = 4'd4,
    S_MOVE_A    = 4'd5,
    S_MOVE_B    = 4'd6,
    S_LAST_A    = 4'd7,
    S_LAST_EMIT = 4'd8,
    S_DONE      = 4'd9
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [N_W-1:0] cnt;
  logic [N_W-1:0] n_reg;
  logic           ovf_q;
  logic [N_W-1:0] cnt_inc;

  assign cnt_inc = cnt + 1'b1;

  // State register; clr_n is sampled on the clock edge only.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!clr_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Term counter, captured term count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt   <= '0;
      n_reg <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // Capture n and drop any stale overflow as the run is accepted.
            n_reg <= n;
            ovf_q <= 1'b0;
          end
        end
        S_CLEAR: begin
          cnt   <= '0;
          ovf_q <= 1'b0;
        end
        S_EMIT: cnt <= cnt_inc;
        S_LAST_EMIT: begin
          cnt <= cnt_inc;
          // Last representable term emitted before n terms were reached.
          if (cnt_inc != n_reg) ovf_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and Moore output decode from state and counter.
  // NOTE: every output gets a default before the case so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    clr_regs   = 1'b0;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    sel_one    = 1'b0;
    ld_t       = 1'b0;
    ld_out     = 1'b0;
    term_valid = 1'b0;
    term_idx   = '0;
    busy       = 1'b1;
    done       = 1'b0;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = (n != '0) ? S_CLEAR : S_DONE;
      end
      S_CLEAR: begin
        clr_regs   = 1'b1;
        state_next = S_INIT;
      end
      S_INIT: begin
        ld_b       = 1'b1;
        sel_one    = 1'b1;
        state_next = S_EMIT;
      end
      S_EMIT: begin
        ld_out     = 1'b1;
        term_valid = 1'b1;
        term_idx   = cnt;
        state_next = (cnt_inc == n_reg) ? S_DONE : S_SUM;
      end
      S_SUM: begin
        ld_t       = 1'b1;
        state_next = carry ? S_LAST_A : S_MOVE_A;
      end
      S_MOVE_A: begin
        ld_a       = 1'b1;
        state_next = S_MOVE_B;
      end
      S_MOVE_B: begin
        ld_b       = 1'b1;
        state_next = S_EMIT;
      end
      S_LAST_A: begin
        ld_a       = 1'b1;
        state_next = S_LAST_EMIT;
      end
      S_LAST_EMIT: begin
        ld_out     = 1'b1;
        term_valid = 1'b1;
        term_idx   = cnt;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_fib_ctrl.sv
// tb_fib_ctrl: directed bench for fib_ctrl with a falling-edge reference
// datapath (A, B, T, OUT, adder) driven by the controller's outputs.
module tb_fib_ctrl;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       start;
  logic [7:0] n;
  logic       carry;
  logic       clr_regs, ld_a, ld_b, sel_one, ld_t, ld_out, term_valid;
  logic [7:0] term_idx;
  logic       busy, done, ovf;

  int checks   = 0;
  int failures = 0;

  // Reference datapath registers.
  logic [7:0] a_r, b_r, t_r, out_r;
  logic [8:0] sum_w;

  // Expected Fibonacci terms F0..F13 (entries past F13 are never expected).
  logic [7:0] fib_exp [0:15] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8,
                                 8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144,
                                 8'd233, 8'd0, 8'd0};

  fib_ctrl #(.N_W(8)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .start      (start),
    .n          (n),
    .carry      (carry),
    .clr_regs   (clr_regs),
    .ld_a       (ld_a),
    .ld_b       (ld_b),
    .sel_one    (sel_one),
    .ld_t       (ld_t),
    .ld_out     (ld_out),
    .term_valid (term_valid),
    .term_idx   (term_idx),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  assign sum_w = {1'b0, a_r} + {1'b0, b_r};
  assign carry = sum_w[8];

  // Datapath registers capture on the falling edge.
  always @(negedge clk) begin
    if (clr_regs) begin
      a_r   <= 8'd0;
      b_r   <= 8'd0;
      t_r   <= 8'd0;
      out_r <= 8'd0;
    end else begin
      if (ld_a)   a_r   <= b_r;
      if (ld_b)   b_r   <= sel_one ? 8'd1 : t_r;
      if (ld_t)   t_r   <= sum_w[7:0];
      if (ld_out) out_r <= a_r;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected emit cycle of the 0-based term k for a run accepted at edge 0.
  function automatic int term_cycle(input int k);
    return (k < 13) ? 3 + 4 * k : 54;
  endfunction

  // One full run: accept at edge 0, observe each cycle until back in IDLE.
  task automatic run_case(input string tag, input logic [7:0] nv, input int exp_terms,
                          input int exp_done, input logic exp_ovf, input bit pulse);
    int   terms     = 0;
    int   done_cyc  = -1;
    int   clr_cyc   = -1;
    int   init_cyc  = -1;
    int   idx_q     = 0;
    bit   pend      = 1'b0;
    bit   idle_seen = 1'b0;
    logic done_ovf  = 1'b0;

    @(negedge clk);
    n     = nv;
    start = 1'b1;
    step();
    start = 1'b0;
    n     = 8'hFF;  // changing n after acceptance must not matter
    check({tag, "_ovf_c1"}, 32'(ovf), 32'd0);

    for (int c = 1; c <= 300; c++) begin
      if (pend) begin
        check({tag, "_out"}, 32'(out_r), 32'(fib_exp[idx_q]));
        pend = 1'b0;
      end
      if (clr_regs && clr_cyc < 0) clr_cyc = c;
      if (ld_b && sel_one && init_cyc < 0) init_cyc = c;
      if (term_valid) begin
        check({tag, "_idx"}, 32'(term_idx), 32'(terms));
        check({tag, "_tcyc"}, 32'(c), 32'(term_cycle(terms)));
        idx_q = (terms > 15) ? 15 : terms;
        pend  = 1'b1;
        terms++;
      end
      if (done) begin
        done_cyc = c;
        done_ovf = ovf;
      end
      if (!busy) begin
        idle_seen = 1'b1;
        break;
      end
      if (pulse) start = (c % 5 == 2);
      step();
    end
    start = 1'b0;

    check({tag, "_terms"}, 32'(terms), 32'(exp_terms));
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
    check({tag, "_done_ovf"}, 32'(done_ovf), 32'(exp_ovf));
    check({tag, "_idle_ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, "_clr_cyc"}, 32'(clr_cyc), (nv != 0) ? 32'd1 : 32'hFFFF_FFFF);
    check({tag, "_init_cyc"}, 32'(init_cyc), (nv != 0) ? 32'd2 : 32'hFFFF_FFFF);
    check({tag, "_idle"}, 32'(idle_seen), 32'd1);
  endtask

  initial begin
    logic [17:0] outs;
    bit          hit;

    clr_n = 1'b0;
    start = 1'b0;
    n     = 8'd0;
    repeat (3) step();
    outs = {clr_regs, ld_a, ld_b, sel_one, ld_t, ld_out, term_valid, term_idx, busy, done, ovf};
    check("reset_outs", 32'(outs), 32'd0);
    @(negedge clk);
    clr_n = 1'b1;

    run_case("n1", 8'd1, 1, 4, 1'b0, 1'b0);
    run_case("n5", 8'd5, 5, 20, 1'b0, 1'b1);
    run_case("n14", 8'd14, 14, 55, 1'b0, 1'b0);
    run_case("n20", 8'd20, 14, 55, 1'b1, 1'b0);
    run_case("n2", 8'd2, 2, 8, 1'b0, 1'b0);
    run_case("n0", 8'd0, 0, 1, 1'b0, 1'b1);

    // Reset in MOVE_B of an n=5 run.
    @(negedge clk);
    n     = 8'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    hit   = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (ld_b && !sel_one) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    check("midrun_moveb_seen", 32'(hit), 32'd1);
    clr_n = 1'b0;
    step();
    outs = {clr_regs, ld_a, ld_b, sel_one, ld_t, ld_out, term_valid, term_idx, busy, done, ovf};
    check("midrun_reset_outs", 32'(outs), 32'd0);
    clr_n = 1'b1;
    run_case("n3_after_rst", 8'd3, 3, 12, 1'b0, 1'b0);

    // start coincident with reset is not captured.
    @(negedge clk);
    clr_n = 1'b0;
    start = 1'b1;
    n     = 8'd3;
    step();
    check("rst_start_busy", 32'(busy), 32'd0);
    clr_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    step();
    check("rst_start_idle", 32'(busy), 32'd0);

    // start held high through DONE re-arms in the following IDLE cycle.
    @(negedge clk);
    n     = 8'd1;
    start = 1'b1;
    hit   = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      step();
      if (done) begin
        hit = 1'b1;
        break;
      end
    end
    check("held_done_seen", 32'(hit), 32'd1);
    step();
    check("held_idle", 32'(busy), 32'd0);
    step();
    check("held_reaccept", 32'(clr_regs), 32'd1);
    start = 1'b0;
    hit   = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      step();
      if (!busy) begin
        hit = 1'b1;
        break;
      end
    end
    check("held_run_ends", 32'(hit), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
